fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 2-stage pipeline. It is the producer side of D_BUS.
- Holds a 16x8 program memory, the PC and the instruction register (IR), and drives IR onto D_BUS for the ALU/execute stage.
- Resolves JMP/JNC using the ALU's registered cflag, flushes the wrong-path fetch with a bubble, and handles run/stall with carry preservation.

Parameters:
- NOP_INSTR, 8'hC0, bubble instruction: loads no register in alu_ctrl (as a side effect the ALU clears cflag).
- OP_JMP, 4'hF, unconditional jump opcode (D_BUS[7:4]).
- OP_JNC, 4'hE, jump-if-no-carry opcode.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  1 = execute; 0 = stall.
- cflag  in  1  registered carry from the ALU.
- prog_we  in  1  program-memory write enable.
- prog_addr  in  4  program-memory write address.
- prog_data  in  8  program-memory write data.
- D_BUS  out  8  instruction to execute stage: {opcode[7:4], imm[3:0]}.
- pc_out  out  4  current PC (next fetch address).
- halted  out  1  executing instruction is a JMP to its own address.

Behaviour:
- Reset (asynchronous, reset=0):
  - PC=0, IR=NOP_INSTR, ir_pc=0, state=IDLE, saved_c=0, use_saved=0.
  - D_BUS=NOP_INSTR, halted=0, pc_out=0.
  - Memory contents are not reset. Reset mid-run aborts everything immediately.
- Memory:
  - Synchronous write on the edge where prog_we=1. Allowed in any state.
  - Fetch read is synchronous (IR<=mem[PC]).
  - Same-edge read and write of the same address: the fetch gets the OLD data.
- D_BUS = IR when state==RUN, else NOP_INSTR. The instruction on D_BUS in cycle t completes at edge t+1.
- Effective carry: eff_c = use_saved ? saved_c : cflag.
- FSM states IDLE, RUN, HOLD:
  - IDLE: D_BUS=NOP. On an edge with run=1: IR<=mem[0], ir_pc<=0, PC<=1, ->RUN.
  - RUN, per edge (regardless of run):
    - taken = (IR op==OP_JMP) | (IR op==OP_JNC & eff_c==0).
    - If taken: PC<=imm, IR<=NOP_INSTR (flush).
    - Else: IR<=mem[PC], ir_pc<=PC, PC<=PC+1 (mod 16, 15 wraps to 0).
    - use_saved<=0.
    - If run=0 at this edge: ->HOLD, hold_first<=1.
  - HOLD:
    - D_BUS=NOP. PC, IR and ir_pc are frozen.
    - On the first HOLD edge: saved_c<=cflag (the result of the last real instruction).
    - On an edge with run=1: ->RUN, use_saved<=1, so the first resumed instruction's JNC uses saved_c.
- Taken-jump cost: exactly one bubble cycle. The bubble clears cflag, so an instruction right after a taken jump sees carry 0.
- JNC not taken (eff_c=1): no bubble.
- halted = (state==RUN) & (IR op==OP_JMP) & (imm==ir_pc). Combinational. The PC keeps looping.
- Jump to address 15 followed by sequential execution wraps to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - OP_* opcode constants and NOP_INSTR;
  - fetch state enum {IDLE, RUN, HOLD};
  - instruction field slices (opcode [7:4], imm [3:0]).
- One sub-module: prog_mem16x8 (16x8 synchronous-read, single-write-port memory).
- PC/IR/FSM logic stays in fetch_unit.

Test Plan:
- Load mem[0..2]={8'h31,8'h52,8'h03}, run=1 from IDLE -> D_BUS shows NOP, then 31, 52, 03 on consecutive cycles; pc_out 1, 2, 3.
- mem[0]=8'hF5, mem[5]=8'h3A -> D_BUS: F5, C0 (bubble), 3A. pc_out after the jump edge = 5.
- JNC 8'hE7 at addr 2 with cflag=1 -> falls through to mem[3], no bubble. Same program with cflag=0 -> C0, then mem[7].
- Drop run while IR=8'hE9, with cflag=1 during the first HOLD cycle and cflag=0 afterwards. Resume -> E9 not taken (saved_c=1 used) and the next D_BUS is mem[next].
- mem[4]=8'hF4 -> halted=1 every cycle F4 is on D_BUS, with C0 bubbles in between.
- Assert reset while pc_out=9 -> D_BUS=C0 and pc_out=0 immediately. Memory is intact on re-run.
- Write mem[15]=8'h70 with no jump, run to 15 -> next fetch is mem[0] (wrap).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 2-stage CPU: opcodes, bubble instruction, fetch FSM
// states and instruction field helpers.
package cpu_pkg;

  // Bubble instruction. It loads no register in alu_ctrl, and as a side effect
  // the ALU clears cflag.
  localparam logic [7:0] NOP_INSTR = 8'hC0;

  // Jump opcodes, found in instruction bits [7:4]
  localparam logic [3:0] OP_JMP = 4'hF;
  localparam logic [3:0] OP_JNC = 4'hE;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } fetch_state_e;

  // Opcode field of an instruction word
  function automatic logic [3:0] instr_op(input logic [7:0] instr);
    return instr[7:4];
  endfunction

  // Immediate / jump-target field of an instruction word
  function automatic logic [3:0] instr_imm(input logic [7:0] instr);
    return instr[3:0];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-execute bus. The fetch stage (master) drives the instruction, PC and
// halt indication; the execute stage (slave) returns its registered carry.
interface fetch_unit_if;
  logic [7:0] D_BUS;
  logic [3:0] pc_out;
  logic       halted;
  logic       cflag;

  modport master (
    output D_BUS,
    output pc_out,
    output halted,
    input  cflag
  );

  modport slave (
    input  D_BUS,
    input  pc_out,
    input  halted,
    output cflag
  );
endinterface

// File: rtl/prog_mem16x8.sv
// 16x8 program memory with one write port. The array is read combinationally and
// the fetch stage registers the word into IR, which makes the fetch a synchronous
// read. A write and a fetch of the same address on one edge return the old word.
module prog_mem16x8 (
  input  logic       clock,
  input  logic       we_i,
  input  logic [3:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic [3:0] raddr_i,
  output logic [7:0] rdata_o
);

  logic [7:0] mem_q [16];

  // Program load; contents are deliberately not reset
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program memory, PC, IR and the IDLE/RUN/HOLD control.
// Resolves JMP/JNC against the ALU carry, flushes a wrong-path fetch with a
// bubble, and preserves the carry across a stall.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                run,
  input  logic                prog_we,
  input  logic [3:0]          prog_addr,
  input  logic [7:0]          prog_data,
  fetch_unit_if.master        bus
);

  fetch_state_e state_q, state_d;
  logic [3:0]   pc_q, pc_d;
  logic [7:0]   ir_q, ir_d;
  logic [3:0]   ir_pc_q, ir_pc_d;
  logic         saved_c_q, saved_c_d;
  logic         use_saved_q, use_saved_d;
  logic         hold_first_q, hold_first_d;

  logic [3:0]   mem_raddr;
  logic [7:0]   mem_rdata;
  logic         eff_c;
  logic         taken;

  // IDLE always fetches address 0; otherwise the PC addresses the next fetch
  assign mem_raddr = (state_q == StIdle) ? 4'd0 : pc_q;

  prog_mem16x8 u_prog_mem (
    .clock   (clock),
    .we_i    (prog_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  // After a resume the live cflag reflects the stall bubbles, so the first
  // resumed instruction uses the carry captured on entry to HOLD.
  assign eff_c = use_saved_q ? saved_c_q : bus.cflag;
  assign taken = (instr_op(ir_q) == OP_JMP) ||
                 ((instr_op(ir_q) == OP_JNC) && !eff_c);

  // Next-state logic for PC, IR and the fetch FSM
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ir_pc_d      = ir_pc_q;
    saved_c_d    = saved_c_q;
    use_saved_d  = use_saved_q;
    hold_first_d = hold_first_q;

    unique case (state_q)
      StIdle: begin
        if (run) begin
          ir_d    = mem_rdata;
          ir_pc_d = 4'd0;
          pc_d    = 4'd1;
          state_d = StRun;
        end
      end

      StRun: begin
        if (taken) begin
          // Discard the sequential fetch; the bubble costs one cycle
          pc_d = instr_imm(ir_q);
          ir_d = NOP_INSTR;
        end else begin
          ir_d    = mem_rdata;
          ir_pc_d = pc_q;
          pc_d    = pc_q + 4'd1;
        end
        use_saved_d = 1'b0;
        if (!run) begin
          state_d      = StHold;
          hold_first_d = 1'b1;
        end
      end

      StHold: begin
        // First HOLD edge: cflag is still the result of the last real instruction
        if (hold_first_q) begin
          saved_c_d    = bus.cflag;
          hold_first_d = 1'b0;
        end
        if (run) begin
          state_d     = StRun;
          use_saved_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pc_q         <= 4'd0;
      ir_q         <= NOP_INSTR;
      ir_pc_q      <= 4'd0;
      saved_c_q    <= 1'b0;
      use_saved_q  <= 1'b0;
      hold_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ir_pc_q      <= ir_pc_d;
      saved_c_q    <= saved_c_d;
      use_saved_q  <= use_saved_d;
      hold_first_q <= hold_first_d;
    end
  end

  // Only RUN presents the IR to execute; IDLE and HOLD present bubbles
  assign bus.D_BUS  = (state_q == StRun) ? ir_q : NOP_INSTR;
  assign bus.pc_out = pc_q;
  assign bus.halted = (state_q == StRun) && (instr_op(ir_q) == OP_JMP) &&
                      (instr_imm(ir_q) == ir_pc_q);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. The bench plays the ALU by
// driving cflag directly. Outputs are sampled 1 time unit after each rising edge.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = 4'd0;
  logic [7:0] prog_data = 8'd0;

  int checks = 0;
  int errors = 0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) write_mem(4'(i), NOP_INSTR);
  endtask

  task automatic do_reset();
    run   = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.D_BUS !== 8'hC0) begin
      errors++;
      $display("FAIL reset_dbus got %h want c0", bus.D_BUS);
    end
    checks++;
    if (bus.pc_out !== 4'd0) begin
      errors++;
      $display("FAIL reset_pc got %0d want 0", bus.pc_out);
    end
    checks++;
    if (bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL reset_halted got %b want 0", bus.halted);
    end
  endtask

  task automatic test_sequential();
    logic [7:0] exp_d [3] = '{8'h31, 8'h52, 8'h03};
    write_mem(4'd0, 8'h31);
    write_mem(4'd1, 8'h52);
    write_mem(4'd2, 8'h03);
    write_mem(4'd3, 8'h04);
    do_reset();
    bus.cflag = 1'b0;
    run = 1'b1;
    checks++;
    if (bus.D_BUS !== 8'hC0) begin
      errors++;
      $display("FAIL seq_idle_dbus got %h want c0", bus.D_BUS);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.D_BUS !== exp_d[i]) begin
        errors++;
        $display("FAIL seq_dbus[%0d] got %h want %h", i, bus.D_BUS, exp_d[i]);
      end
      checks++;
      if (bus.pc_out !== 4'(i + 1)) begin
        errors++;
        $display("FAIL seq_pc[%0d] got %0d want %0d", i, bus.pc_out, i + 1);
      end
    end
    // Overwrite mem[3] on the same edge that fetches it: old word expected
    prog_we   = 1'b1;
    prog_addr = 4'd3;
    prog_data = 8'h99;
    step();
    prog_we = 1'b0;
    checks++;
    if (bus.D_BUS !== 8'h04) begin
      errors++;
      $display("FAIL seq_rw_collision got %h want 04", bus.D_BUS);
    end
    run = 1'b0;
  endtask

  task automatic test_jump();
    write_mem(4'd0, 8'hF5);
    write_mem(4'd5, 8'h3A);
    do_reset();
    run = 1'b1;
    step();
    checks++;
    if (bus.D_BUS !== 8'hF5 || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL jmp_first got %h/%b want f5/0", bus.D_BUS, bus.halted);
    end
    step();
    checks++;
    if (bus.D_BUS !== 8'hC0 || bus.pc_out !== 4'd5) begin
      errors++;
      $display("FAIL jmp_bubble got %h/pc%0d want c0/pc5", bus.D_BUS, bus.pc_out);
    end
    step();
    checks++;
    if (bus.D_BUS !== 8'h3A || bus.pc_out !== 4'd6) begin
      errors++;
      $display("FAIL jmp_target got %h/pc%0d want 3a/pc6", bus.D_BUS, bus.pc_out);
    end
    run = 1'b0;
  endtask

  task automatic test_jnc();
    write_mem(4'd0, 8'hC0);
    write_mem(4'd1, 8'hC0);
    write_mem(4'd2, 8'hE7);
    write_mem(4'd3, 8'h21);
    write_mem(4'd7, 8'h47);
    // Carry set: fall through, no bubble
    do_reset();
    bus.cflag = 1'b1;
    run = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.D_BUS !== 8'hE7 || bus.pc_out !== 4'd3) begin
      errors++;
      $display("FAIL jnc_c1_instr got %h/pc%0d want e7/pc3", bus.D_BUS, bus.pc_out);
    end
    step();
    checks++;
    if (bus.D_BUS !== 8'h21 || bus.pc_out !== 4'd4) begin
      errors++;
      $display("FAIL jnc_c1_fall got %h/pc%0d want 21/pc4", bus.D_BUS, bus.pc_out);
    end
    // Carry clear: taken, one bubble then mem[7]
    do_reset();
    bus.cflag = 1'b0;
    run = 1'b1;
    repeat (3) step();
    step();
    checks++;
    if (bus.D_BUS !== 8'hC0 || bus.pc_out !== 4'd7) begin
      errors++;
      $display("FAIL jnc_c0_bubble got %h/pc%0d want c0/pc7", bus.D_BUS, bus.pc_out);
    end
    step();
    checks++;
    if (bus.D_BUS !== 8'h47 || bus.pc_out !== 4'd8) begin
      errors++;
      $display("FAIL jnc_c0_target got %h/pc%0d want 47/pc8", bus.D_BUS, bus.pc_out);
    end
    run = 1'b0;
  endtask

  task automatic test_hold();
    write_mem(4'd0, 8'h31);
    write_mem(4'd1, 8'hE9);
    write_mem(4'd2, 8'h42);
    write_mem(4'd9, 8'h55);
    do_reset();
    bus.cflag = 1'b0;
    run = 1'b1;
    step();
    checks++;
    if (bus.D_BUS !== 8'h31) begin
      errors++;
      $display("FAIL hold_pre got %h want 31", bus.D_BUS);
    end
    run = 1'b0;
    step();                 // E9 loaded into IR, enter HOLD
    checks++;
    if (bus.D_BUS !== 8'hC0 || bus.pc_out !== 4'd2) begin
      errors++;
      $display("FAIL hold_enter got %h/pc%0d want c0/pc2", bus.D_BUS, bus.pc_out);
    end
    bus.cflag = 1'b1;       // carry of the last real instruction
    step();
    bus.cflag = 1'b0;       // stall bubbles clear the live carry
    step();
    checks++;
    if (bus.D_BUS !== 8'hC0 || bus.pc_out !== 4'd2) begin
      errors++;
      $display("FAIL hold_frozen got %h/pc%0d want c0/pc2", bus.D_BUS, bus.pc_out);
    end
    run = 1'b1;
    step();
    checks++;
    if (bus.D_BUS !== 8'hE9 || bus.pc_out !== 4'd2) begin
      errors++;
      $display("FAIL hold_resume got %h/pc%0d want e9/pc2", bus.D_BUS, bus.pc_out);
    end
    step();
    checks++;
    if (bus.D_BUS !== 8'h42 || bus.pc_out !== 4'd3) begin
      errors++;
      $display("FAIL hold_saved_c got %h/pc%0d want 42/pc3", bus.D_BUS, bus.pc_out);
    end
    run = 1'b0;
  endtask

  task automatic test_halt();
    for (int i = 0; i < 4; i++) write_mem(4'(i), 8'hC0);
    write_mem(4'd4, 8'hF4);
    do_reset();
    run = 1'b1;
    repeat (5) step();
    checks++;
    if (bus.D_BUS !== 8'hF4 || bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_first got %h/%b want f4/1", bus.D_BUS, bus.halted);
    end
    step();
    checks++;
    if (bus.D_BUS !== 8'hC0 || bus.halted !== 1'b0 || bus.pc_out !== 4'd4) begin
      errors++;
      $display("FAIL halt_bubble got %h/%b/pc%0d want c0/0/pc4", bus.D_BUS, bus.halted,
               bus.pc_out);
    end
    step();
    checks++;
    if (bus.D_BUS !== 8'hF4 || bus.halted !== 1'b1) begin
      errors++;
      $display("FAIL halt_loop got %h/%b want f4/1", bus.D_BUS, bus.halted);
    end
    run = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    write_mem(4'd0, 8'h12);
    for (int i = 1; i < 9; i++) write_mem(4'(i), 8'hC0);
    do_reset();
    run = 1'b1;
    repeat (9) step();
    checks++;
    if (bus.pc_out !== 4'd9) begin
      errors++;
      $display("FAIL mid_pre_pc got %0d want 9", bus.pc_out);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.D_BUS !== 8'hC0 || bus.pc_out !== 4'd0) begin
      errors++;
      $display("FAIL mid_async got %h/pc%0d want c0/pc0", bus.D_BUS, bus.pc_out);
    end
    #1 reset = 1'b1;
    step();
    checks++;
    if (bus.D_BUS !== 8'h12 || bus.pc_out !== 4'd1) begin
      errors++;
      $display("FAIL mid_mem_kept got %h/pc%0d want 12/pc1", bus.D_BUS, bus.pc_out);
    end
    run = 1'b0;
  endtask

  task automatic test_wrap();
    write_mem(4'd0, 8'hFF);
    write_mem(4'd15, 8'h70);
    do_reset();
    run = 1'b1;
    step();
    checks++;
    if (bus.D_BUS !== 8'hFF || bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL wrap_jmp got %h/%b want ff/0", bus.D_BUS, bus.halted);
    end
    step();
    checks++;
    if (bus.pc_out !== 4'd15) begin
      errors++;
      $display("FAIL wrap_pc15 got %0d want 15", bus.pc_out);
    end
    step();
    checks++;
    if (bus.D_BUS !== 8'h70 || bus.pc_out !== 4'd0) begin
      errors++;
      $display("FAIL wrap_last got %h/pc%0d want 70/pc0", bus.D_BUS, bus.pc_out);
    end
    step();
    checks++;
    if (bus.D_BUS !== 8'hFF || bus.pc_out !== 4'd1) begin
      errors++;
      $display("FAIL wrap_mem0 got %h/pc%0d want ff/pc1", bus.D_BUS, bus.pc_out);
    end
    run = 1'b0;
  endtask

  initial begin
    bus.cflag = 1'b0;
    clear_mem();
    reset = 1'b1;
    test_reset();
    test_sequential();
    test_jump();
    test_jnc();
    test_hold();
    test_halt();
    test_reset_mid_run();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
